// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the 32-bit CPU front end.
//   WORD_W       - datapath word width in bits
//   INST_BYTES   - bytes per instruction (PC step)
//   word_t       - 32-bit word type
//   fetch_state_t- fetch engine state (RUN / FAULT)
package cpu_pkg;

  localparam int WORD_W     = 32;
  localparam int INST_BYTES = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch initiator for the 32-bit CPU.
// Issues byte addresses to a code memory with a fixed 1-cycle registered
// read latency and presents the returned word, its PC and a valid flag to
// decode. Decode stalls replay the in-flight address so the memory output
// stays put; a taken branch redirects immediately and squashes the slot that
// is on the output in the same cycle. A misaligned or out-of-range response
// halts fetch with a sticky fault that only reset clears.
//
// Ports:
//   clk           in   system clock, posedge
//   reset         in   asynchronous active-high reset
//   mem_addr      out  byte address to code memory
//   mem_inst      in   code memory word for the address sent last cycle
//   stall         in   decode cannot accept; hold current output
//   branch_taken  in   redirect request from execute
//   branch_target in   redirect byte address
//   inst          out  fetched instruction (mem_inst pass-through)
//   inst_pc       out  byte address of inst
//   inst_valid    out  inst/inst_pc meaningful this cycle
//   fetch_fault   out  fetch halted on a bad address
//   fetch_count   out  instructions accepted by decode (wraps)
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int          SIZE     = 1024,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_inst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  // Highest legal word address. Comparing against this directly avoids
  // computing req_pc+3, which would wrap for addresses near 2^32.
  localparam logic [31:0] LAST_ADDR = 32'(SIZE - INST_BYTES);
  localparam logic [31:0] PC_STEP   = 32'(INST_BYTES);

  word_t        r_pc;
  word_t        r_req_pc;
  logic         r_req_valid;
  fetch_state_t r_state;
  word_t        r_fetch_count;
  logic         r_fault_q;

  logic w_bad_now;
  logic w_run;
  logic w_accept;

  // Response currently on mem_inst came from an illegal address.
  assign w_bad_now = r_req_valid &
                     ((r_req_pc[1:0] != 2'b00) | (r_req_pc > LAST_ADDR));

  assign w_run    = (r_state == RUN);
  assign w_accept = inst_valid & ~stall;

  assign inst        = mem_inst;
  assign inst_pc     = r_req_pc;
  assign inst_valid  = w_run & r_req_valid & ~w_bad_now & ~branch_taken;
  // A bad response coinciding with a branch is wrong-path and is ignored.
  assign fetch_fault = r_fault_q | (w_run & w_bad_now & ~branch_taken);
  assign fetch_count = r_fetch_count;

  // Address select towards code memory; FAULT freezes on the bad address,
  // stall replays the in-flight address so mem_inst is unchanged next cycle.
  always_comb begin
    mem_addr = r_pc;
    if (!w_run) begin
      mem_addr = r_req_pc;
    end else if (branch_taken) begin
      mem_addr = branch_target;
    end else if (stall) begin
      mem_addr = r_req_pc;
    end else begin
      mem_addr = r_pc;
    end
  end

  // Fetch state machine: PC sequencing, redirect, stall hold and fault entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_req_pc    <= 32'h0000_0000;
      r_req_valid <= 1'b0;
      r_state     <= RUN;
      r_fault_q   <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (branch_taken) begin
            r_pc        <= branch_target + PC_STEP;
            r_req_pc    <= branch_target;
            r_req_valid <= 1'b1;
          end else if (w_bad_now) begin
            r_state   <= FAULT;
            r_fault_q <= 1'b1;
          end else if (stall) begin
            r_pc        <= r_pc;
            r_req_pc    <= r_req_pc;
            r_req_valid <= r_req_valid;
          end else begin
            r_req_pc    <= r_pc;
            r_pc        <= r_pc + PC_STEP;
            r_req_valid <= 1'b1;
          end
        end
        FAULT: begin
          r_state   <= FAULT;
          r_fault_q <= 1'b1;
        end
        default: begin
          // Unreachable encoding: park in the safe halted state.
          r_state   <= FAULT;
          r_fault_q <= 1'b1;
        end
      endcase
    end
  end

  // Count of instructions handed to decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count <= 32'h0000_0000;
    end else if (w_accept) begin
      r_fetch_count <= r_fetch_count + 32'h0000_0001;
    end else begin
      r_fetch_count <= r_fetch_count;
    end
  end

endmodule : inst_fetch

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch initiator for the 32-bit CPU, and the requesting end of the code memory interface.
- Drives a byte address to code memory and receives the registered 32-bit word one clock later.
- Delivers an instruction, its PC and a valid flag to decode.
- Handles decode stalls by replaying the in-flight address, and taken-branch redirects with a single squashed slot.
- Detects misaligned and out-of-bounds fetches and halts with a sticky fault.

Parameters:
- SIZE, 1024: code memory size in bytes; must match the code memory instance.
- RESET_PC, 32'h0: first byte address fetched after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- mem_addr  out  32  byte address to code memory.
- mem_inst  in  32  code memory word; valid 1 cycle after mem_addr is presented.
- stall  in  1  decode cannot accept; hold the current output.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  32  redirect byte address.
- inst  out  32  fetched instruction (= mem_inst).
- inst_pc  out  32  byte address of inst.
- inst_valid  out  1  inst/inst_pc are meaningful this cycle.
- fetch_fault  out  1  fetch halted on a bad address.
- fetch_count  out  32  number of instructions accepted by decode.

Behaviour:
- Registers and reset values:
  - pc = RESET_PC: next address to request.
  - req_pc = 0: address whose data is on mem_inst.
  - req_valid = 0.
  - state = RUN.
  - fetch_count = 0.
  - fault_q = 0.
- Outputs during reset: inst_valid=0, fetch_fault=0, mem_addr=RESET_PC.
- Reset asserted mid-operation clears everything immediately. The first request after release is RESET_PC; the first inst_valid comes one cycle later.
- Code memory latency is exactly 1 cycle.
  - inst = mem_inst and inst_pc = req_pc, combinational.
- bad_now = req_valid & (req_pc[1:0]!=0 | req_pc > SIZE-4).
  - Compare directly; never compute req_pc+3, which wraps near 2^32.
- inst_valid = state==RUN & req_valid & !bad_now & !branch_taken.
- mem_addr select, priority highest first:
  - state==FAULT: req_pc.
  - branch_taken: branch_target.
  - stall: req_pc (replay, so mem_inst is unchanged next cycle).
  - else: pc.
- State RUN, per posedge, priority highest first:
  - branch_taken: pc<=branch_target+4, req_pc<=branch_target, req_valid<=1. The current output slot is squashed. A bad response in the same cycle is wrong-path and raises no fault.
  - bad_now: state<=FAULT, fault_q<=1; pc/req_pc held.
  - stall: pc, req_pc, req_valid held.
  - else: req_pc<=pc, pc<=pc+4 (mod 2^32), req_valid<=1.
- State FAULT:
  - Terminal until reset. branch_taken and stall are ignored.
  - inst_valid=0, mem_addr=req_pc.
- fetch_fault = fault_q | (state==RUN & bad_now & !branch_taken).
  - High in the detecting cycle, sticky afterwards.
- fetch_count increments when inst_valid & !stall; wraps mod 2^32.
- Simultaneous stall and branch_taken: branch wins; the stalled instruction is discarded.
- Branch to a misaligned or out-of-range target: the request is issued; the fault is raised when the response arrives (next cycle) unless squashed by another branch.
- The last in-range word at SIZE-4 is legal. Fetching SIZE faults.

Decomposition:
- cpu_pkg holds:
  - WORD_W=32, INST_BYTES=4.
  - Typedef fetch_state_t {RUN, FAULT}.
  - Typedef word_t = logic [31:0].
- No sub-module; a single flat module. The fault check is one combinational expression, not a block.

Test Plan:
- Reset release, memory holds 0x11,0x22,0x33 at words 0..2, no stall -> mem_addr 0,4,8 on successive cycles; inst_valid rises one cycle after release; inst/inst_pc = 0x11/0, 0x22/4, 0x33/8; fetch_count = 3.
- Stall high 3 cycles while inst_pc=4 -> inst=0x22, inst_pc=4, inst_valid=1 held; mem_addr=4 throughout; fetch_count unchanged; after release the next inst_pc=8.
- branch_taken with target 0x40 while inst_pc=8 -> inst_valid=0 that cycle; mem_addr=0x40; next cycle inst_pc=0x40, then 0x44.
- Sequential fetch up to SIZE=1024 -> inst_pc=1020 is valid; the response for 1024 gives inst_valid=0 and fetch_fault=1; fault stays set through a later branch_taken to 0; mem_addr frozen.
- branch_taken to target 0x42 -> next cycle fetch_fault=1 and inst_valid=0. Repeat with a second branch to 0x10 in that response cycle -> no fault, inst_pc=0x10 follows.
- Assert reset while in FAULT and mid-stall -> fetch_fault=0, fetch_count=0, inst_valid=0 immediately (asynchronous); fetch restarts at RESET_PC.
